tlul_host_requester: RTL and testbench
======================================

// Module: tlul_host_requester
// PURPOSE
//  TL-UL initiator (host) that turns a simple word-level request/response interface into TL-UL
//  A-channel Get/PutFullData/PutPartialData requests and collects D-channel responses.
//  Signals are flat RocketChip-style master_a_*/master_d_*; it drives slave-side TL-UL blocks such as the scratchpad.
//  Up to MAX_OUTSTANDING requests may be in flight, tagged by source ID; responses may return in any order.
// PARAMETERS
//  TL_AW 32 address width | TL_DW 64 data width | TL_SZW 3 size width | TL_AIW 8 source width
//  TL_DIW 1 sink width | MAX_OUTSTANDING 4 source IDs 0..N-1 (2..2**TL_AIW)
//  TIMEOUT_CYCLES 1024 response watchdog limit (>=2)
// PORTS
//  clk              in   1      clock; all logic on rising edge
//  rst              in   1      synchronous, active-high reset
//  req_valid        in   1      request present
//  req_ready        out  1      request accepted when req_valid&req_ready
//  req_write        in   1      1=write, 0=read
//  req_address      in   TL_AW  byte address; low log2(TL_DW/8) bits forced to 0
//  req_wdata        in   TL_DW  write data
//  req_mask         in   TL_DW/8 byte enables
//  rsp_valid        out  1      response present
//  rsp_ready        in   1      response consumed when rsp_valid&rsp_ready
//  rsp_rdata        out  TL_DW  read data (0 for writes)
//  rsp_source       out  TL_AIW source ID of the completed request
//  rsp_error        out  1      denied/corrupt/protocol error on this response
//  req_source       out  TL_AIW source ID allocated to the request accepted this cycle
//  master_a_opcode/param/size/source/address/mask/data/corrupt/valid  out  3/3/SZW/AIW/AW/DW/8/DW/1/1
//  master_a_ready   in   1
//  master_d_opcode/param/size/source/sink/denied/data/corrupt/valid   in   3/3/SZW/AIW/DIW/1/DW/1/1
//  master_d_ready   out  1
//  timeout          out  1      sticky watchdog expiry
//  unexpected_rsp   out  1      sticky: D response on a source ID that is not pending
// BEHAVIOUR
//  Reset: all outputs 0 (incl. master_a_valid, rsp_valid, master_d_ready, timeout, unexpected_rsp).
//    pending bitmap cleared; watchdog = 0.
//  A channel: one A register. req_ready = (!a_valid_q | master_a_ready) & any free source & !timeout.
//  On accept:
//    - allocate lowest-index free source; set pending[src]; pending_wr[src] = req_write.
//    - load A register; master_a_valid = 1 the next cycle; hold stable until master_a_ready.
//    - back-to-back accept is allowed in the same cycle the prior A beat fires.
//    - Latency: 1 cycle from req fire to master_a_valid.
//  Opcode: read -> Get 3'h4; write with mask all-ones -> PutFullData 3'h0; else PutPartialData 3'h1.
//  Fixed fields: a_size = log2(TL_DW/8), a_param = 0, a_corrupt = 0, a_mask = req_mask (Get included).
//  D channel: one-entry rsp register. master_d_ready = !rsp_valid | rsp_ready (only when not in reset).
//  On D fire: capture into rsp register (rsp_valid next cycle) and clear pending[d_source].
//    - rsp_rdata = d_data if d_opcode == AccessAckData 3'h1, else 0.
//    - rsp_error = d_denied | d_corrupt | source not pending | opcode mismatch.
//      Mismatch: write expects 3'h0, read expects 3'h1.
//    - Source not pending: also set unexpected_rsp; pending unchanged.
//  Simultaneous accept and D fire: a source freed by D fire is NOT reusable in that same cycle.
//    Allocation uses the registered bitmap.
//  Watchdog: clears on any D fire or when the pending bitmap is empty; otherwise increments by 1.
//    - At TIMEOUT_CYCLES: set timeout (sticky until rst); req_ready held 0.
//    - A/D channels keep draining normally.
//  Reset mid-transaction: synchronous rst drops master_a_valid even without master_a_ready.
//    Pending responses are forgotten. A late D response after reset reports unexpected_rsp.
// TESTING
//  1 Read: req read addr 0x1000 -> A: opcode 4, addr 0x1000, size 3, source 0; D AccessAckData 0xDEADBEEF_CAFEF00D
//    -> rsp_rdata = that data, rsp_error 0, rsp_source 0.
//  2 Writes: mask 0xFF -> opcode 0; mask 0x0F -> opcode 1.
//    D AccessAck -> rsp_rdata 0, rsp_error 0; pending clears.
//  3 Issue 4 reads with a_ready=1 and D stalled -> sources 0,1,2,3, req_ready 0 after 4th.
//    Return D src 2 -> rsp_source 2; next request is allocated src 2.
//  4 Backpressure: a_ready=0 for 5 cycles -> A fields stable.
//    rsp_ready=0 -> master_d_ready 0 while rsp_valid; no response lost.
//  5 D response src 3 with no pending -> rsp_error 1, unexpected_rsp 1.
//    d_denied=1 on a valid read -> rsp_error 1.
//  6 TIMEOUT_CYCLES=16, one read, no D -> timeout 1 at cycle 16 after the last D/empty event, req_ready 0.
//    rst pulse -> timeout 0, master_a_valid 0.

Source files
------------

// File: rtl/tlul_host_requester.sv
// TL-UL host requester: turns word-level read/write requests into A-channel Get/Put beats
// and collects out-of-order D-channel responses tagged by source ID.
module tlul_host_requester #(
  parameter int unsigned TL_AW           = 32,
  parameter int unsigned TL_DW           = 64,
  parameter int unsigned TL_SZW          = 3,
  parameter int unsigned TL_AIW          = 8,
  parameter int unsigned TL_DIW          = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [TL_AW-1:0]     req_address,
  input  logic [TL_DW-1:0]     req_wdata,
  input  logic [TL_DW/8-1:0]   req_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TL_DW-1:0]     rsp_rdata,
  output logic [TL_AIW-1:0]    rsp_source,
  output logic                 rsp_error,
  output logic [TL_AIW-1:0]    req_source,
  output logic [2:0]           master_a_opcode,
  output logic [2:0]           master_a_param,
  output logic [TL_SZW-1:0]    master_a_size,
  output logic [TL_AIW-1:0]    master_a_source,
  output logic [TL_AW-1:0]     master_a_address,
  output logic [TL_DW/8-1:0]   master_a_mask,
  output logic [TL_DW-1:0]     master_a_data,
  output logic                 master_a_corrupt,
  output logic                 master_a_valid,
  input  logic                 master_a_ready,
  input  logic [2:0]           master_d_opcode,
  input  logic [2:0]           master_d_param,
  input  logic [TL_SZW-1:0]    master_d_size,
  input  logic [TL_AIW-1:0]    master_d_source,
  input  logic [TL_DIW-1:0]    master_d_sink,
  input  logic                 master_d_denied,
  input  logic [TL_DW-1:0]     master_d_data,
  input  logic                 master_d_corrupt,
  input  logic                 master_d_valid,
  output logic                 master_d_ready,
  output logic                 timeout,
  output logic                 unexpected_rsp
);

  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned A_SIZE = $clog2(TL_DBW);
  localparam int unsigned WDW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TL_AW-1:0] ADDR_ALIGN = ~TL_AW'(TL_DBW - 1);

  localparam logic [2:0] OP_GET       = 3'h4;
  localparam logic [2:0] OP_PUT_FULL  = 3'h0;
  localparam logic [2:0] OP_PUT_PART  = 3'h1;
  localparam logic [2:0] OP_ACK       = 3'h0;
  localparam logic [2:0] OP_ACK_DATA  = 3'h1;

  logic                       r_a_valid;
  logic [2:0]                 r_a_opcode;
  logic [TL_SZW-1:0]          r_a_size;
  logic [TL_AIW-1:0]          r_a_source;
  logic [TL_AW-1:0]           r_a_address;
  logic [TL_DBW-1:0]          r_a_mask;
  logic [TL_DW-1:0]           r_a_data;
  logic [MAX_OUTSTANDING-1:0] r_pending;
  logic [MAX_OUTSTANDING-1:0] r_pending_wr;
  logic                       r_rsp_valid;
  logic [TL_DW-1:0]           r_rsp_rdata;
  logic [TL_AIW-1:0]          r_rsp_source;
  logic                       r_rsp_error;
  logic [WDW-1:0]             r_wdog;
  logic                       r_timeout;
  logic                       r_unexpected;

  logic                       w_any_free;
  logic [TL_AIW-1:0]          w_alloc;
  logic [MAX_OUTSTANDING-1:0] w_alloc_oh;
  logic [MAX_OUTSTANDING-1:0] w_d_oh;
  logic                       w_d_pend;
  logic                       w_d_wr;
  logic                       w_req_ready;
  logic                       w_req_fire;
  logic                       w_d_ready;
  logic                       w_d_fire;
  logic                       w_d_err;
  logic [2:0]                 w_exp_op;
  logic                       w_wdog_clr;
  logic                       w_unused_d;

  // Lowest-index free source from the registered bitmap (same-cycle frees are not visible).
  always_comb begin
    w_any_free = 1'b0;
    w_alloc    = '0;
    w_alloc_oh = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!r_pending[i]) begin
        w_any_free    = 1'b1;
        w_alloc       = TL_AIW'(i);
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
  end

  // Pending lookup for the returning source; out-of-range IDs never match.
  always_comb begin
    w_d_oh   = '0;
    w_d_pend = 1'b0;
    w_d_wr   = 1'b0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (master_d_source == TL_AIW'(i)) begin
        w_d_oh[i] = r_pending[i];
        w_d_pend  = r_pending[i];
        w_d_wr    = r_pending_wr[i];
      end
    end
  end

  always_comb begin
    w_req_ready = !rst && (!r_a_valid || master_a_ready) && w_any_free && !r_timeout;
    w_req_fire  = req_valid && w_req_ready;
    w_d_ready   = !rst && (!r_rsp_valid || rsp_ready);
    w_d_fire    = master_d_valid && w_d_ready;
    w_exp_op    = w_d_wr ? OP_ACK : OP_ACK_DATA;
    w_d_err     = master_d_denied || master_d_corrupt || !w_d_pend ||
                  (master_d_opcode != w_exp_op);
    w_wdog_clr  = w_d_fire || (r_pending == '0);
  end

  assign w_unused_d = ^{master_d_param, master_d_size, master_d_sink};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid    <= 1'b0;
      r_a_opcode   <= '0;
      r_a_size     <= '0;
      r_a_source   <= '0;
      r_a_address  <= '0;
      r_a_mask     <= '0;
      r_a_data     <= '0;
      r_pending    <= '0;
      r_pending_wr <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_source <= '0;
      r_rsp_error  <= 1'b0;
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
      r_unexpected <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_a_valid   <= 1'b1;
        r_a_opcode  <= !req_write ? OP_GET : ((&req_mask) ? OP_PUT_FULL : OP_PUT_PART);
        r_a_size    <= TL_SZW'(A_SIZE);
        r_a_source  <= w_alloc;
        r_a_address <= req_address & ADDR_ALIGN;
        r_a_mask    <= req_mask;
        r_a_data    <= req_wdata;
      end else if (master_a_ready) begin
        r_a_valid <= 1'b0;
      end

      r_pending <= (r_pending & ~(w_d_fire ? w_d_oh : '0)) | (w_req_fire ? w_alloc_oh : '0);
      if (w_req_fire) begin
        r_pending_wr <= (r_pending_wr & ~w_alloc_oh) | (req_write ? w_alloc_oh : '0);
      end

      // A new capture takes priority over the pop happening on the same edge.
      if (w_d_fire) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_rdata  <= (master_d_opcode == OP_ACK_DATA) ? master_d_data : '0;
        r_rsp_source <= master_d_source;
        r_rsp_error  <= w_d_err;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_d_fire && !w_d_pend) begin
        r_unexpected <= 1'b1;
      end

      if (w_wdog_clr) begin
        r_wdog <= '0;
      end else if (r_wdog != WDW'(TIMEOUT_CYCLES)) begin
        r_wdog <= r_wdog + WDW'(1);
      end
      if (!w_wdog_clr && (r_wdog == WDW'(TIMEOUT_CYCLES - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign req_ready        = w_req_ready;
  assign req_source       = w_req_fire ? w_alloc : '0;
  assign master_d_ready   = w_d_ready;
  assign master_a_valid   = r_a_valid;
  assign master_a_opcode  = r_a_opcode;
  assign master_a_param   = 3'h0;
  assign master_a_size    = r_a_size;
  assign master_a_source  = r_a_source;
  assign master_a_address = r_a_address;
  assign master_a_mask    = r_a_mask;
  assign master_a_data    = r_a_data;
  assign master_a_corrupt = 1'b0;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_source       = r_rsp_source;
  assign rsp_error        = r_rsp_error;
  assign timeout          = r_timeout;
  assign unexpected_rsp   = r_unexpected;

endmodule

// File: tb/tb_tlul_host_requester.sv
// Directed bench for tlul_host_requester: read/write opcodes, source allocation,
// backpressure, error reporting, watchdog and mid-transaction reset.
module tb_tlul_host_requester;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [63:0] req_wdata;
  logic [7:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [7:0]  rsp_source;
  logic        rsp_error;
  logic [7:0]  req_source;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic [0:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic        timeout;
  logic        unexpected_rsp;

  int checks = 0;
  int failures = 0;

  tlul_host_requester #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_source(rsp_source), .rsp_error(rsp_error), .req_source(req_source),
    .master_a_opcode(a_opcode), .master_a_param(a_param), .master_a_size(a_size),
    .master_a_source(a_source), .master_a_address(a_address), .master_a_mask(a_mask),
    .master_a_data(a_data), .master_a_corrupt(a_corrupt), .master_a_valid(a_valid),
    .master_a_ready(a_ready),
    .master_d_opcode(d_opcode), .master_d_param(d_param), .master_d_size(d_size),
    .master_d_source(d_source), .master_d_sink(d_sink), .master_d_denied(d_denied),
    .master_d_data(d_data), .master_d_corrupt(d_corrupt), .master_d_valid(d_valid),
    .master_d_ready(d_ready),
    .timeout(timeout), .unexpected_rsp(unexpected_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, confirm it is accepted with the expected source, then drop it.
  task automatic send_req(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] m, input logic [7:0] exp_src);
    req_valid = 1'b1; req_write = w; req_address = addr; req_wdata = wd; req_mask = m;
    #1;
    chk("req_ready", 64'(req_ready), 64'd1);
    chk("req_source", 64'(req_source), 64'(exp_src));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [7:0] src, input logic [63:0] data,
                        input logic den, input logic cor);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = data; d_denied = den; d_corrupt = cor;
    #1;
    chk("d_ready", 64'(d_ready), 64'd1);
    tick();
    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
  endtask

  task automatic chk_rsp(input logic [63:0] data, input logic [7:0] src, input logic err);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_rdata", rsp_rdata, data);
    chk("rsp_source", 64'(rsp_source), 64'(src));
    chk("rsp_error", 64'(rsp_error), 64'(err));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
    req_mask = '0; rsp_ready = 1'b1; a_ready = 1'b0; d_opcode = '0; d_param = '0;
    d_size = 3'd3; d_source = '0; d_sink = '0; d_denied = 1'b0; d_data = '0;
    d_corrupt = 1'b0; d_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1; a_ready = 1'b1;
    #1;
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_unexp", 64'(unexpected_rsp), 64'd0);
    req_valid = 1'b0; a_ready = 1'b0; rst = 1'b0;
    tick();
    chk("post_rst_d_ready", 64'(d_ready), 64'd1);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Single read with misaligned address bits forced low.
    send_req(1'b0, 32'h0000_1007, 64'h0, 8'hFF, 8'd0);
    chk("rd_a_valid", 64'(a_valid), 64'd1);
    chk("rd_a_opcode", 64'(a_opcode), 64'h4);
    chk("rd_a_addr", 64'(a_address), 64'h1000);
    chk("rd_a_size", 64'(a_size), 64'd3);
    chk("rd_a_source", 64'(a_source), 64'd0);
    chk("rd_a_param", 64'(a_param), 64'd0);
    chk("rd_a_corrupt", 64'(a_corrupt), 64'd0);
    chk("rd_a_mask", 64'(a_mask), 64'hFF);
    chk("rd_req_ready_blocked", 64'(req_ready), 64'd0);
    a_ready = 1'b1;
    #1;
    chk("rd_req_ready_aready", 64'(req_ready), 64'd1);
    tick();
    chk("rd_a_valid_drop", 64'(a_valid), 64'd0);
    send_d(3'h1, 8'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
    chk_rsp(64'hDEADBEEF_CAFEF00D, 8'd0, 1'b0);
    tick();
    chk("rd_rsp_pop", 64'(rsp_valid), 64'd0);

    // Full and partial writes, issued back to back.
    send_req(1'b1, 32'h0000_2000, 64'h1122_3344_5566_7788, 8'hFF, 8'd0);
    chk("wr_full_op", 64'(a_opcode), 64'h0);
    chk("wr_full_data", a_data, 64'h1122_3344_5566_7788);
    send_req(1'b1, 32'h0000_2008, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 8'd1);
    chk("wr_part_op", 64'(a_opcode), 64'h1);
    chk("wr_part_mask", 64'(a_mask), 64'h0F);
    chk("wr_part_src", 64'(a_source), 64'd1);
    chk("wr_part_addr", 64'(a_address), 64'h2008);
    tick();
    send_d(3'h0, 8'd0, 64'h0, 1'b0, 1'b0);
    chk_rsp(64'h0, 8'd0, 1'b0);
    send_d(3'h0, 8'd1, 64'hFFFF, 1'b0, 1'b0);
    chk_rsp(64'h0, 8'd1, 1'b0);

    // Fill all four sources, then free src 2 while a request waits.
    send_req(1'b0, 32'h100, 64'h0, 8'hFF, 8'd0);
    send_req(1'b0, 32'h108, 64'h0, 8'hFF, 8'd1);
    send_req(1'b0, 32'h110, 64'h0, 8'hFF, 8'd2);
    send_req(1'b0, 32'h118, 64'h0, 8'hFF, 8'd3);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h120; req_mask = 8'hFF;
    d_valid = 1'b1; d_opcode = 3'h1; d_source = 8'd2; d_data = 64'h2222;
    #1;
    chk("full_req_ready", 64'(req_ready), 64'd0);
    chk("full_d_ready", 64'(d_ready), 64'd1);
    tick();
    d_valid = 1'b0;
    #1;
    chk_rsp(64'h2222, 8'd2, 1'b0);
    chk("realloc_ready", 64'(req_ready), 64'd1);
    chk("realloc_src", 64'(req_source), 64'd2);
    tick();
    req_valid = 1'b0;
    send_d(3'h1, 8'd0, 64'hA0, 1'b0, 1'b0);
    chk_rsp(64'hA0, 8'd0, 1'b0);
    send_d(3'h1, 8'd1, 64'hA1, 1'b0, 1'b0);
    chk_rsp(64'hA1, 8'd1, 1'b0);
    send_d(3'h1, 8'd3, 64'hA3, 1'b0, 1'b0);
    chk_rsp(64'hA3, 8'd3, 1'b0);
    send_d(3'h1, 8'd2, 64'hA2, 1'b0, 1'b0);
    chk_rsp(64'hA2, 8'd2, 1'b0);

    // A-channel stall: fields must hold while a_ready is low.
    a_ready = 1'b0;
    send_req(1'b0, 32'h3008, 64'h0, 8'hF0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_a_valid", 64'(a_valid), 64'd1);
      chk("stall_a_addr", 64'(a_address), 64'h3008);
      chk("stall_a_mask", 64'(a_mask), 64'hF0);
      chk("stall_a_op", 64'(a_opcode), 64'h4);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    a_ready = 1'b1;
    tick();
    chk("stall_release", 64'(a_valid), 64'd0);
    send_req(1'b0, 32'h3010, 64'h0, 8'hFF, 8'd1);
    tick();

    // Response stall: second D beat must wait and not be lost.
    rsp_ready = 1'b0;
    send_d(3'h1, 8'd0, 64'h4444, 1'b0, 1'b0);
    chk_rsp(64'h4444, 8'd0, 1'b0);
    chk("rstall_d_ready", 64'(d_ready), 64'd0);
    d_valid = 1'b1; d_opcode = 3'h1; d_source = 8'd1; d_data = 64'h5555;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstall_hold_data", rsp_rdata, 64'h4444);
      chk("rstall_hold_ready", 64'(d_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rstall_d_ready_back", 64'(d_ready), 64'd1);
    tick();
    d_valid = 1'b0;
    chk_rsp(64'h5555, 8'd1, 1'b0);
    tick();
    chk("rstall_drained", 64'(rsp_valid), 64'd0);

    // Errors: unexpected source, denied read, opcode mismatch on a write.
    send_d(3'h0, 8'd3, 64'h0, 1'b0, 1'b0);
    chk_rsp(64'h0, 8'd3, 1'b1);
    chk("unexp_flag", 64'(unexpected_rsp), 64'd1);
    send_req(1'b0, 32'h4000, 64'h0, 8'hFF, 8'd0);
    tick();
    send_d(3'h1, 8'd0, 64'h77, 1'b1, 1'b0);
    chk_rsp(64'h77, 8'd0, 1'b1);
    send_req(1'b1, 32'h4008, 64'h99, 8'hFF, 8'd0);
    tick();
    send_d(3'h1, 8'd0, 64'h55, 1'b0, 1'b0);
    chk_rsp(64'h55, 8'd0, 1'b1);
    tick();

    // Watchdog: 16 cycles with a request pending and no D beat.
    send_req(1'b0, 32'h5000, 64'h0, 8'hFF, 8'd0);
    for (int k = 0; k < 15; k++) tick();
    chk("wdog_not_yet", 64'(timeout), 64'd0);
    tick();
    chk("wdog_fired", 64'(timeout), 64'd1);
    req_valid = 1'b1;
    #1;
    chk("wdog_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst2_timeout", 64'(timeout), 64'd0);
    chk("rst2_unexp", 64'(unexpected_rsp), 64'd0);
    chk("rst2_d_ready", 64'(d_ready), 64'd0);
    rst = 1'b0; a_ready = 1'b0;
    tick();

    // Reset while an A beat is stalled, then a late D response.
    send_req(1'b0, 32'h6000, 64'h0, 8'hFF, 8'd0);
    chk("mid_a_valid", 64'(a_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
    rst = 1'b0;
    tick();
    send_d(3'h1, 8'd0, 64'h88, 1'b0, 1'b0);
    chk_rsp(64'h88, 8'd0, 1'b1);
    chk("late_unexp", 64'(unexpected_rsp), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
